// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: per-channel rising-edge capture with round-robin serialization
// onto a single valid/ready event port; lost edges are flagged in sticky overflow bits.
module edge_event_arbiter #(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic [N-1:0]   d,
   input  logic [N-1:0]   en,
   input  logic           evt_ready,
   input  logic [N-1:0]   ovf_clr,
   output logic           evt_valid,
   output logic [IDW-1:0] evt_id,
   output logic [N-1:0]   pending,
   output logic [N-1:0]   overflow
);
   logic [N-1:0]   d_q;
   logic [N-1:0]   edge_det;
   logic [N-1:0]   gnt;
   logic [IDW-1:0] last;
   logic [IDW-1:0] lo_idx;
   logic [IDW-1:0] hi_idx;
   logic [IDW-1:0] win;
   logic           lo_f;
   logic           hi_f;
   logic           free;
   logic           grant;
   assign edge_det = d & ~d_q & en;
   assign free     = !evt_valid || evt_ready;
   // Lowest pending index above last wins; otherwise wrap to the lowest pending overall.
   always_comb begin
      lo_idx = '0;
      hi_idx = '0;
      lo_f   = 1'b0;
      hi_f   = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (pending[i]) begin
            lo_idx = IDW'(i);
            lo_f   = 1'b1;
            if (i > int'(last)) begin
               hi_idx = IDW'(i);
               hi_f   = 1'b1;
            end
         end
      end
   end
   assign win   = hi_f ? hi_idx : lo_idx;
   assign grant = free && lo_f;
   assign gnt   = grant ? (N'(1) << win) : '0;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         d_q       <= '0;
         pending   <= '0;
         overflow  <= '0;
         evt_valid <= 1'b0;
         evt_id    <= '0;
         last      <= IDW'(N - 1);
      end else begin
         d_q <= d;
         if (free) begin
            evt_valid <= grant;
            if (grant) begin
               evt_id <= win;
               last   <= win;
            end
         end
         // A new edge beats a same-cycle grant clear; disable beats everything.
         pending  <= ((pending & ~gnt) | edge_det) & en;
         overflow <= (overflow & ~ovf_clr) | (edge_det & pending & ~gnt);
      end
   end
endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed vector table plus hand-written reset and latency sequences.
module tb_edge_event_arbiter;
   logic       clk;
   logic       rstn;
   logic [3:0] d;
   logic [3:0] en;
   logic       evt_ready;
   logic [3:0] ovf_clr;
   logic       evt_valid;
   logic [1:0] evt_id;
   logic [3:0] pending;
   logic [3:0] overflow;
   int tests = 0;
   int fails = 0;
   typedef struct {
      logic       rst;
      logic [3:0] d;
      logic [3:0] en;
      logic       rdy;
      logic [3:0] clr;
      logic       v;
      logic [1:0] id;
      logic [3:0] p;
      logic [3:0] o;
   } vec_t;
   vec_t vq[$];
   edge_event_arbiter #(.N(4), .IDW(2)) dut (
      .clk(clk), .rstn(rstn), .d(d), .en(en), .evt_ready(evt_ready), .ovf_clr(ovf_clr),
      .evt_valid(evt_valid), .evt_id(evt_id), .pending(pending), .overflow(overflow)
   );
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   function automatic void add(logic rst, logic [3:0] dd, logic [3:0] ee, logic rdy, logic [3:0] clr,
                               logic v, logic [1:0] id, logic [3:0] p, logic [3:0] o);
      vec_t t;
      t.rst = rst; t.d = dd; t.en = ee; t.rdy = rdy; t.clr = clr;
      t.v = v; t.id = id; t.p = p; t.o = o;
      vq.push_back(t);
   endfunction
   task automatic chk(string nm, logic v, logic [1:0] id, logic [3:0] p, logic [3:0] o);
      tests++;
      if ({evt_valid, evt_id, pending, overflow} !== {v, id, p, o}) begin
         fails++;
         $display("FAIL %s: got valid=%b id=%0d pending=%b overflow=%b, expected valid=%b id=%0d pending=%b overflow=%b",
                  nm, evt_valid, evt_id, pending, overflow, v, id, p, o);
      end
   endtask
   initial begin
      rstn = 1'b0; d = '0; en = 4'hf; evt_ready = 1'b1; ovf_clr = '0;
      // round robin from a fresh reset
      add(1, 4'h0, 4'hf, 1, 4'h0, 0, 0, 4'h0, 4'h0);
      add(0, 4'hf, 4'hf, 1, 4'h0, 0, 0, 4'hf, 4'h0);
      add(0, 4'hf, 4'hf, 1, 4'h0, 1, 0, 4'he, 4'h0);
      add(0, 4'hf, 4'hf, 1, 4'h0, 1, 1, 4'hc, 4'h0);
      add(0, 4'hf, 4'hf, 1, 4'h0, 1, 2, 4'h8, 4'h0);
      add(0, 4'hf, 4'hf, 1, 4'h0, 1, 3, 4'h0, 4'h0);
      add(0, 4'h0, 4'hf, 1, 4'h0, 0, 3, 4'h0, 4'h0);
      add(0, 4'ha, 4'hf, 1, 4'h0, 0, 3, 4'ha, 4'h0);
      add(0, 4'h0, 4'hf, 1, 4'h0, 1, 1, 4'h8, 4'h0);
      add(0, 4'h0, 4'hf, 1, 4'h0, 1, 3, 4'h0, 4'h0);
      add(0, 4'h0, 4'hf, 1, 4'h0, 0, 3, 4'h0, 4'h0);
      // backpressure
      add(0, 4'h6, 4'hf, 0, 4'h0, 0, 3, 4'h6, 4'h0);
      add(0, 4'h6, 4'hf, 0, 4'h0, 1, 1, 4'h4, 4'h0);
      for (int i = 0; i < 5; i++) add(0, 4'h6, 4'hf, 0, 4'h0, 1, 1, 4'h4, 4'h0);
      add(0, 4'h6, 4'hf, 1, 4'h0, 1, 2, 4'h0, 4'h0);
      add(0, 4'h0, 4'hf, 1, 4'h0, 0, 2, 4'h0, 4'h0);
      // overflow on channel 2 while channel 1 blocks the port
      add(0, 4'h2, 4'hf, 0, 4'h0, 0, 2, 4'h2, 4'h0);
      add(0, 4'h2, 4'hf, 0, 4'h0, 1, 1, 4'h0, 4'h0);
      add(0, 4'h6, 4'hf, 0, 4'h0, 1, 1, 4'h4, 4'h0);
      for (int i = 0; i < 3; i++) add(0, 4'h2, 4'hf, 0, 4'h0, 1, 1, 4'h4, 4'h0);
      add(0, 4'h6, 4'hf, 0, 4'h0, 1, 1, 4'h4, 4'h4);
      add(0, 4'h2, 4'hf, 0, 4'h0, 1, 1, 4'h4, 4'h4);
      add(0, 4'h6, 4'hf, 0, 4'h4, 1, 1, 4'h4, 4'h4);
      add(0, 4'h2, 4'hf, 0, 4'h4, 1, 1, 4'h4, 4'h0);
      add(0, 4'h2, 4'hf, 0, 4'h0, 1, 1, 4'h4, 4'h0);
      add(0, 4'h2, 4'hf, 1, 4'h0, 1, 2, 4'h0, 4'h0);
      add(0, 4'h0, 4'hf, 1, 4'h0, 0, 2, 4'h0, 4'h0);
      // set-wins race on channel 1
      add(0, 4'h1, 4'hf, 0, 4'h0, 0, 2, 4'h1, 4'h0);
      add(0, 4'h3, 4'hf, 0, 4'h0, 1, 0, 4'h2, 4'h0);
      add(0, 4'h1, 4'hf, 0, 4'h0, 1, 0, 4'h2, 4'h0);
      add(0, 4'h3, 4'hf, 1, 4'h0, 1, 1, 4'h2, 4'h0);
      add(0, 4'h1, 4'hf, 1, 4'h0, 1, 1, 4'h0, 4'h0);
      add(0, 4'h0, 4'hf, 1, 4'h0, 0, 1, 4'h0, 4'h0);
      // enables
      add(0, 4'h8, 4'h7, 1, 4'h0, 0, 1, 4'h0, 4'h0);
      add(0, 4'h0, 4'hf, 1, 4'h0, 0, 1, 4'h0, 4'h0);
      add(0, 4'h2, 4'hf, 0, 4'h0, 0, 1, 4'h2, 4'h0);
      add(0, 4'h3, 4'hf, 0, 4'h0, 1, 1, 4'h1, 4'h0);
      add(0, 4'h3, 4'he, 0, 4'h0, 1, 1, 4'h0, 4'h0);
      add(0, 4'h0, 4'hf, 1, 4'h0, 0, 1, 4'h0, 4'h0);
      // leave an event presented and another pending for the async reset check
      add(0, 4'h4, 4'hf, 0, 4'h0, 0, 1, 4'h4, 4'h0);
      add(0, 4'h6, 4'hf, 0, 4'h0, 1, 2, 4'h2, 4'h0);
      // single edge with exact timing: reset released at 13 ns, d[0] rises at 10 ns
      #2 chk("reset_state", 0, 0, 4'h0, 4'h0);
      #8 d = 4'h1;
      #3 rstn = 1'b1;
      @(posedge clk); #1 chk("single_pending", 0, 0, 4'h1, 4'h0);
      @(posedge clk); #1 chk("single_valid", 1, 0, 4'h0, 4'h0);
      @(posedge clk); #1 chk("single_idle", 0, 0, 4'h0, 4'h0);
      foreach (vq[k]) begin
         rstn = !vq[k].rst; d = vq[k].d; en = vq[k].en; evt_ready = vq[k].rdy; ovf_clr = vq[k].clr;
         @(posedge clk); #1 chk($sformatf("vec%0d", k), vq[k].v, vq[k].id, vq[k].p, vq[k].o);
      end
      rstn = 1'b0; d = 4'h0; ovf_clr = '0;
      #1 chk("async_reset", 0, 0, 4'h0, 4'h0);
      @(posedge clk); #1 rstn = 1'b1; evt_ready = 1'b1;
      @(posedge clk); #1 chk("post_reset_1", 0, 0, 4'h0, 4'h0);
      @(posedge clk); #1 chk("post_reset_2", 0, 0, 4'h0, 4'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
